fifo_share_ctrl: RTL and testbench

Controller that shares one single-port-write FIFO storage array between NREQ writers and one reader. Round-robin arbitrates writer requests, owns the write/read pointers and occupancy count, and drives fifo_full, fifo_empty, push and pop. push is never issued while full and pop is never issued while empty. Sits between the requesting agents and the FIFO storage RAM; the existing fifo interface checkers observe its push/pop/full/empty outputs.

---
 rtl/fifo_share_pkg.sv | 25 ++
 rtl/fifo_share_ctrl_if.sv | 39 +++
 rtl/fifo_share_ctrl_rr_arbiter.sv | 32 +++
 rtl/fifo_share_ctrl.sv | 96 +++++++++
 tb/tb_fifo_share_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_share_pkg.sv
// Shared definitions for the shared-FIFO controller: default sizes, the
// pointer/count record and the round-robin pointer helper.
package fifo_share_pkg;

   localparam int unsigned NREQ_DEF  = 4;
   localparam int unsigned WIDTH_DEF = 8;
   localparam int unsigned DEPTH_DEF = 16;

   // Record fields are sized for the largest supported DEPTH; unused upper bits stay zero.
   localparam int unsigned PTR_W = 16;

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [PTR_W:0]   cnt_t;

   typedef struct packed {
      ptr_t wr_ptr;
      ptr_t rd_ptr;
      cnt_t count;
   } ptr_rec_t;

   function automatic int unsigned next_rr(input int unsigned idx, input int unsigned nreq);
      return (idx + 1 >= nreq) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/fifo_share_ctrl_if.sv
// Writer/reader/storage signal bundle of the shared-FIFO controller.
// master = requesting agents and storage side, slave = the controller.
interface fifo_share_ctrl_if
   import fifo_share_pkg::*;
#(
   parameter int unsigned NREQ  = NREQ_DEF,
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [NREQ-1:0]       gnt;
   logic                  pop_req;
   logic                  push;
   logic                  pop;
   logic [AW-1:0]         mem_waddr;
   logic [WIDTH-1:0]      mem_wdata;
   logic [AW-1:0]         mem_raddr;
   logic                  rd_valid;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [AW:0]           count;
   logic                  pop_refused;

   modport master (
      output req, wdata, pop_req,
      input  gnt, push, pop, mem_waddr, mem_wdata, mem_raddr,
             rd_valid, fifo_full, fifo_empty, count, pop_refused
   );

   modport slave (
      input  req, wdata, pop_req,
      output gnt, push, pop, mem_waddr, mem_wdata, mem_raddr,
             rd_valid, fifo_full, fifo_empty, count, pop_refused
   );

endinterface

// File: rtl/fifo_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// rr_ptr (modulo NREQ) when enabled.
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic            enable,
   input  logic [IW-1:0]   rr_ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_idx,
   output logic            gnt_valid
);

   logic [IW-1:0] cand;

   always_comb begin
      gnt       = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      cand      = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = IW'((32'(rr_ptr) + k) % NREQ);
         if (enable && !gnt_valid && req[cand]) begin
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
            gnt_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_share_ctrl.sv
// Shared FIFO controller: arbitrates NREQ writers onto one external storage
// array and owns pointers, occupancy and full/empty flags.
module fifo_share_ctrl
   import fifo_share_pkg::*;
#(
   parameter int unsigned NREQ  = NREQ_DEF,
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   fifo_share_ctrl_if.slave bus
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam int unsigned IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam ptr_t        LAST_PTR = ptr_t'(DEPTH - 1);
   localparam cnt_t        FULL_CNT = cnt_t'(DEPTH);

   ptr_rec_t        rec_q, rec_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic            full_q, full_d;
   logic            empty_q, empty_d;
   logic            rd_valid_q;
   logic            refused_q, refused_d;

   logic [NREQ-1:0] gnt;
   logic [IW-1:0]   gnt_idx;
   logic            gnt_valid;
   logic            push;
   logic            pop;

   // Gating on registered full means a pop at full frees the slot for the next cycle only.
   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .req       (bus.req),
      .enable    (rst_n & ~full_q),
      .rr_ptr    (rr_ptr_q),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   assign push = gnt_valid;
   assign pop  = bus.pop_req & ~empty_q & rst_n;

   always_comb begin
      rec_d    = rec_q;
      rr_ptr_d = rr_ptr_q;
      if (push) begin
         rec_d.wr_ptr = (rec_q.wr_ptr == LAST_PTR) ? '0 : rec_q.wr_ptr + 1'b1;
         rr_ptr_d     = IW'(next_rr(32'(gnt_idx), NREQ));
      end
      if (pop) begin
         rec_d.rd_ptr = (rec_q.rd_ptr == LAST_PTR) ? '0 : rec_q.rd_ptr + 1'b1;
      end
      case ({push, pop})
         2'b10:   rec_d.count = rec_q.count + 1'b1;
         2'b01:   rec_d.count = rec_q.count - 1'b1;
         default: rec_d.count = rec_q.count;
      endcase
      full_d    = (rec_d.count == FULL_CNT);
      empty_d   = (rec_d.count == '0);
      refused_d = bus.pop_req & empty_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rec_q      <= '0;
         rr_ptr_q   <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         rd_valid_q <= 1'b0;
         refused_q  <= 1'b0;
      end else begin
         rec_q      <= rec_d;
         rr_ptr_q   <= rr_ptr_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         rd_valid_q <= pop;
         refused_q  <= refused_d;
      end
   end

   assign bus.gnt         = gnt;
   assign bus.push        = push;
   assign bus.pop         = pop;
   assign bus.mem_waddr   = rec_q.wr_ptr[AW-1:0];
   assign bus.mem_raddr   = rec_q.rd_ptr[AW-1:0];
   assign bus.mem_wdata   = bus.wdata[gnt_idx*WIDTH +: WIDTH];
   assign bus.rd_valid    = rd_valid_q;
   assign bus.fifo_full   = full_q;
   assign bus.fifo_empty  = empty_q;
   assign bus.count       = rec_q.count[AW:0];
   assign bus.pop_refused = refused_q;

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// Directed bench for fifo_share_ctrl (NREQ=4, WIDTH=8, DEPTH=16): arbitration
// order, full/empty gating, pointer wrap, pop refusal and async reset.
module tb_fifo_share_ctrl;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 16;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   fifo_share_ctrl_if #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   fifo_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.req     = 4'b1111;
      bus.wdata   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      bus.pop_req = 1'b0;

      // reset held: no grant even with all writers requesting
      @(negedge clk);
      check_eq("rst_gnt",   32'(bus.gnt), 32'h0);
      check_eq("rst_push",  32'(bus.push), 32'h0);
      check_eq("rst_count", 32'(bus.count), 32'd0);
      check_eq("rst_empty", 32'(bus.fifo_empty), 32'h1);
      check_eq("rst_full",  32'(bus.fifo_full), 32'h0);
      check_eq("rst_rdv",   32'(bus.rd_valid), 32'h0);
      check_eq("rst_refused", 32'(bus.pop_refused), 32'h0);
      tick();

      rst_n   = 1'b1;
      bus.req = 4'b0000;
      @(negedge clk);
      check_eq("idle_count", 32'(bus.count), 32'd0);
      check_eq("idle_empty", 32'(bus.fifo_empty), 32'h1);
      check_eq("idle_gnt",   32'(bus.gnt), 32'h0);
      tick();

      // all four requesting: 0,1,2,3,0,1,2,3
      bus.req = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check_eq("rr_gnt",   32'(bus.gnt), 32'(1 << (k % 4)));
         check_eq("rr_wdata", 32'(bus.mem_wdata), 32'(8'hA0 + (k % 4)));
         check_eq("rr_waddr", 32'(bus.mem_waddr), 32'(k));
         check_eq("rr_count", 32'(bus.count), 32'(k));
         tick();
      end
      bus.req = 4'b0000;
      @(negedge clk);
      check_eq("rr_count8", 32'(bus.count), 32'd8);
      check_eq("rr_empty",  32'(bus.fifo_empty), 32'h0);
      tick();

      // fill with writer 2 only
      bus.req = 4'b0100;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check_eq("fill_gnt",   32'(bus.gnt), 32'h4);
         check_eq("fill_wdata", 32'(bus.mem_wdata), 32'hA2);
         check_eq("fill_count", 32'(bus.count), 32'(8 + k));
         tick();
      end
      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         check_eq("full_flag", 32'(bus.fifo_full), 32'h1);
         check_eq("full_gnt",  32'(bus.gnt), 32'h0);
         check_eq("full_push", 32'(bus.push), 32'h0);
         check_eq("full_count", 32'(bus.count), 32'd16);
         tick();
      end
      bus.pop_req = 1'b1;
      @(negedge clk);
      check_eq("fullpop_pop", 32'(bus.pop), 32'h1);
      check_eq("fullpop_gnt", 32'(bus.gnt), 32'h0);
      check_eq("fullpop_raddr", 32'(bus.mem_raddr), 32'd0);
      tick();
      bus.pop_req = 1'b0;
      @(negedge clk);
      check_eq("resume_full",  32'(bus.fifo_full), 32'h0);
      check_eq("resume_gnt",   32'(bus.gnt), 32'h4);
      check_eq("resume_count", 32'(bus.count), 32'd15);
      check_eq("resume_rdv",   32'(bus.rd_valid), 32'h1);
      check_eq("resume_waddr", 32'(bus.mem_waddr), 32'd0);
      tick();
      @(negedge clk);
      check_eq("refull_count", 32'(bus.count), 32'd16);
      check_eq("refull_flag",  32'(bus.fifo_full), 32'h1);
      check_eq("refull_gnt",   32'(bus.gnt), 32'h0);
      check_eq("refull_rdv",   32'(bus.rd_valid), 32'h0);
      tick();
      bus.req = 4'b0000;

      // drain with pop_req held
      bus.pop_req = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         check_eq("drain_pop",   32'(bus.pop), 32'h1);
         check_eq("drain_raddr", 32'(bus.mem_raddr), 32'((1 + k) % 16));
         check_eq("drain_count", 32'(bus.count), 32'(16 - k));
         check_eq("drain_rdv",   32'(bus.rd_valid), 32'(k != 0));
         tick();
      end
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         check_eq("blk_pop",     32'(bus.pop), 32'h0);
         check_eq("blk_empty",   32'(bus.fifo_empty), 32'h1);
         check_eq("blk_rdv",     32'(bus.rd_valid), 32'(b == 0));
         check_eq("blk_refused", 32'(bus.pop_refused), 32'(b != 0));
         tick();
      end

      // push into empty while pop requested: pop stays blocked
      bus.req = 4'b0001;
      @(negedge clk);
      check_eq("epush_pop",   32'(bus.pop), 32'h0);
      check_eq("epush_gnt",   32'(bus.gnt), 32'h1);
      check_eq("epush_waddr", 32'(bus.mem_waddr), 32'd1);
      tick();
      bus.pop_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_eq("up_empty", 32'(bus.fifo_empty), 32'h0);
         check_eq("up_count", 32'(bus.count), 32'(1 + k));
         check_eq("up_waddr", 32'(bus.mem_waddr), 32'(2 + k));
         tick();
      end

      // simultaneous push and pop at count 5, both pointers wrap
      bus.pop_req = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check_eq("pp_count", 32'(bus.count), 32'd5);
         check_eq("pp_waddr", 32'(bus.mem_waddr), 32'((6 + k) % 16));
         check_eq("pp_raddr", 32'(bus.mem_raddr), 32'((1 + k) % 16));
         check_eq("pp_flags", 32'({bus.fifo_full, bus.fifo_empty}), 32'h0);
         check_eq("pp_strobes", 32'({bus.push, bus.pop}), 32'h3);
         tick();
      end
      bus.pop_req = 1'b0;

      // writer 1 only, leaving rr_ptr at 2 before reset
      bus.req = 4'b0010;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check_eq("w1_gnt",   32'(bus.gnt), 32'h2);
         check_eq("w1_count", 32'(bus.count), 32'(5 + k));
         tick();
      end
      bus.req     = 4'b0000;
      bus.pop_req = 1'b1;
      @(negedge clk);
      check_eq("prerst_pop", 32'(bus.pop), 32'h1);
      tick();
      bus.pop_req = 1'b0;
      #1;
      check_eq("prerst_count", 32'(bus.count), 32'd9);
      check_eq("prerst_rdv",   32'(bus.rd_valid), 32'h1);

      // asynchronous reset mid-cycle
      bus.req = 4'b1111;
      rst_n   = 1'b0;
      #1;
      check_eq("arst_count", 32'(bus.count), 32'd0);
      check_eq("arst_rdv",   32'(bus.rd_valid), 32'h0);
      check_eq("arst_empty", 32'(bus.fifo_empty), 32'h1);
      check_eq("arst_full",  32'(bus.fifo_full), 32'h0);
      check_eq("arst_gnt",   32'(bus.gnt), 32'h0);
      check_eq("arst_push",  32'(bus.push), 32'h0);
      check_eq("arst_ptrs",  32'({bus.mem_waddr, bus.mem_raddr}), 32'h0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_gnt",   32'(bus.gnt), 32'h1);
      check_eq("post_wdata", 32'(bus.mem_wdata), 32'hA0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
